inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
Dual-lane instruction buffer between decode and `issue`. It accepts up to two decoded instructions per cycle and presents the two oldest to `issue` as a compacted pair. It retires whatever `issue` reports as issued and absorbs the variable 0/1/2 issue rate so decode keeps streaming. It is flushed on redirect.

Parameters:
- DEPTH, 8, number of instruction entries; power of two, ≥4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush_i  in  1  redirect flush; drops all contents.
- w_inst_i  in  2×inst_t  decoded instructions; lane 0 is older.
- w_valid_i  in  2  write-lane valid: 2'b00, 2'b01 or 2'b11 only.
- w_ready_o  out  1  queue can take a full pair this cycle.
- inst_o  out  2×inst_t  oldest two entries; drives `issue` inst_i.
- valid_o  out  2  entry valid: 2'b00, 2'b01 or 2'b11; drives `issue` d_valid_i.
- issued_i  in  2  from `issue` is_o: 2'b00, 2'b01 or 2'b11.

Behaviour:
- State:
  - rd_ptr and wr_ptr, log2(DEPTH) bits, wrap modulo DEPTH.
  - count, log2(DEPTH)+1 bits.
  - Storage array of inst_t.
- Reset: when rst=1 at an edge, rd_ptr=wr_ptr=count=0. After reset: valid_o=2'b00, w_ready_o=1. inst_o is don't-care while invalid.
- w_ready_o = (DEPTH − count) ≥ 2. It is a function of registered count only, with no comb path from issued_i.
- Write acceptance:
  - Number written nw = popcount(w_valid_i) when w_ready_o=1, else 0.
  - Lane 0 goes to entry[wr_ptr], lane 1 to entry[wr_ptr+1]. wr_ptr += nw.
  - Writes while w_ready_o=0 are dropped; decode must hold them.
- Read side:
  - inst_o[k] = entry[rd_ptr+k].
  - valid_o = 2'b00 if count=0, 2'b01 if count=1, 2'b11 if count≥2.
  - Write-to-output latency is 1 cycle: an entry written at edge N is visible after edge N.
- Retire:
  - ni = popcount(issued_i). rd_ptr += ni.
  - issued_i bits not covered by valid_o are illegal. An implementation masks them with valid_o and never underflows.
- Simultaneous write and issue: count_next = count + nw − ni. Both pointers update in the same edge.
- Full: count=DEPTH−1 deasserts w_ready_o even though 1 entry is free; no partial pair is accepted.
- Wrap-around: lane 1 of a write or read at index DEPTH−1 uses index 0.
- Flush:
  - flush_i=1 forces rd_ptr=wr_ptr=count=0 next edge.
  - Priority is rst > flush_i > write/issue. Writes and issues in the flush cycle are discarded.
- Reset mid-stream: same as flush; no stale valid survives.
- Illegal w_valid_i=2'b10 or issued_i=2'b10 is flagged by a simulation-only assertion.

Optional Feature:
INST_QUEUE_BYPASS_EN
- Defined:
  - When count=0, the incoming w_inst_i/w_valid_i are driven combinationally onto inst_o/valid_o in the same cycle.
  - Lanes issued that cycle are not stored. Only the unissued remainder is written, and wr_ptr/count advance by nw − ni.
  - This adds a decode→issue comb path and saves one cycle of latency when the queue is empty.
- Undefined: outputs always come from storage; 1-cycle latency as above.

Decomposition:
- inst_t stays in the shared pipeline header.
- Add constant INST_QUEUE_DEPTH and a popcount2 helper function to the same header.
- One sub-module: inst_queue_bank.
  - Storage split into even and odd banks by index LSB, so each bank has exactly one write and one read port per cycle.
  - inst_queue does pointer/count control and lane↔bank swizzling on rd_ptr[0]/wr_ptr[0].

Test Plan:
1. Reset release → valid_o=00, w_ready_o=1. Write pair A,B → next cycle valid_o=11, inst_o={B,A}.
2. Write 4 pairs with issued_i=00 (DEPTH=8) → count=8, w_ready_o=0. Fifth pair is held, not lost.
3. count=7 → w_ready_o=0. issued_i=01 → count=6, w_ready_o=1 next cycle.
4. Steady writes of 2 per cycle with issued_i alternating 11/01 → contents stay in order across pointer wrap 7→0. count rises by 1 every 2 cycles until full.
5. count=5 with writes 11 and issued_i=11 plus flush_i=1 → next cycle count=0, valid_o=00. Nothing from that cycle survives.
6. count=1, w_valid_i=11, issued_i=01 → count=2. Old entry retired; new pair becomes inst_o with valid_o=11.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Shared pipeline header: instruction type, queue depth and small helpers.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package inst_queue_pkg;

    // Default number of instruction entries held between decode and issue.
    localparam int INST_QUEUE_DEPTH = 8;

    // Decoded instruction as it travels from decode to issue.
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] op;
    } inst_t;

    // Number of set bits in a 2-bit lane mask (0, 1 or 2).
    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/inst_queue_if.sv
// Decode->queue write bundle and queue->issue read bundle.
// Latency: n/a (wires only).
// Backpressure: w_ready_o throttles decode; issue reports consumption via issued_i.
//   master: decode/issue side (drives w_inst_i, w_valid_i, issued_i)
//   slave : instruction queue (drives w_ready_o, inst_o, valid_o)
interface inst_queue_if;
    import inst_queue_pkg::*;

    inst_t [1:0] w_inst_i;    // lane 0 is the older instruction
    logic  [1:0] w_valid_i;   // 00, 01 or 11
    logic        w_ready_o;   // room for a full pair
    inst_t [1:0] inst_o;      // two oldest entries, lane 0 oldest
    logic  [1:0] valid_o;     // 00, 01 or 11
    logic  [1:0] issued_i;    // lanes consumed by issue: 00, 01 or 11

    modport master (
        output w_inst_i, w_valid_i, issued_i,
        input  w_ready_o, inst_o, valid_o
    );

    modport slave (
        input  w_inst_i, w_valid_i, issued_i,
        output w_ready_o, inst_o, valid_o
    );
endinterface

// File: rtl/inst_queue_bank.sv
// One storage bank (even or odd indices) of the instruction queue.
// Latency: write visible on read port after the next clk edge; read is combinational.
// Backpressure: none, the controller only enables writes it has accepted.
//   Ports: clk; we/waddr/wdata single write port; raddr/rdata single read port.
module inst_queue_bank
    import inst_queue_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int AW      = $clog2(ENTRIES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  inst_t         wdata,
    input  logic [AW-1:0] raddr,
    output inst_t         rdata
);

    // Payload storage needs no reset: validity is tracked by the controller.
    inst_t mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Dual-lane instruction queue: takes up to 2 decoded insts/cycle, presents oldest 2 to issue.
// Latency: 1 cycle write->inst_o; 0 cycles when empty with INST_QUEUE_BYPASS_EN defined.
// Backpressure: w_ready_o=1 only while a full pair fits; writes seen while low are dropped.
//   Ports: clk, rst (sync, active-high), flush_i (redirect), q (inst_queue_if.slave).
//   Optional macro INST_QUEUE_BYPASS_EN: empty-queue combinational bypass decode->issue.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = INST_QUEUE_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    inst_queue_if.slave  q
);

    localparam int PW = $clog2(DEPTH);   // pointer width
    localparam int CW = PW + 1;          // count width, holds 0..DEPTH
    localparam int BW = PW - 1;          // per-bank address width

    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;

    logic          w_ready;
    logic          bypass;
    logic [1:0]    valid_q;
    inst_t [1:0]   inst_q;
    logic [1:0]    nw, ni, st_n, rd_adv;
    inst_t [1:0]   st_inst;
    logic          st_we0, st_we1;

    logic          even_we, odd_we;
    logic [BW-1:0] even_waddr, odd_waddr, even_raddr, odd_raddr;
    inst_t         even_wdata, odd_wdata, even_rdata, odd_rdata;

    // Registered count only, so issue never reaches back into decode's ready.
    assign w_ready     = (count <= CW'(DEPTH - 2));
    assign q.w_ready_o = w_ready;

`ifdef INST_QUEUE_BYPASS_EN
    assign bypass = (count == '0);
`else
    assign bypass = 1'b0;
`endif

    // ---------------- read side ----------------
    // Entry rd_ptr lives in the bank selected by rd_ptr[0]; its neighbour is in
    // the other bank. When rd_ptr is odd the even neighbour is one row further.
    assign odd_raddr  = rd_ptr[PW-1:1];
    assign even_raddr = rd_ptr[PW-1:1] + BW'(rd_ptr[0]);

    assign inst_q[0] = rd_ptr[0] ? odd_rdata  : even_rdata;
    assign inst_q[1] = rd_ptr[0] ? even_rdata : odd_rdata;

    assign valid_q = (count == '0)           ? 2'b00 :
                     (count == CW'(1))       ? 2'b01 : 2'b11;

    assign q.inst_o  = bypass ? q.w_inst_i  : inst_q;
    assign q.valid_o = bypass ? q.w_valid_i : valid_q;

    // Issue may only consume what it was shown; masking keeps count from underflowing.
    assign ni = popcount2(q.issued_i & q.valid_o);
    assign nw = w_ready ? popcount2(q.w_valid_i) : 2'd0;

    // ---------------- write side ----------------
    // In bypass, lanes consumed this cycle never touch storage; the survivors
    // are shifted down so the oldest survivor lands at wr_ptr.
    always_comb begin
        st_n       = nw;
        rd_adv     = ni;
        st_inst[0] = q.w_inst_i[0];
        st_inst[1] = q.w_inst_i[1];
        if (bypass) begin
            st_n   = nw - ni;
            rd_adv = 2'd0;
            if (ni == 2'd1) begin
                st_inst[0] = q.w_inst_i[1];
            end
        end
    end

    assign st_we0 = (st_n != 2'd0) && !flush_i && !rst;
    assign st_we1 = (st_n == 2'd2) && !flush_i && !rst;

    // Lane->bank swizzle, mirror image of the read side.
    assign odd_waddr  = wr_ptr[PW-1:1];
    assign even_waddr = wr_ptr[PW-1:1] + BW'(wr_ptr[0]);
    assign even_we    = wr_ptr[0] ? st_we1     : st_we0;
    assign odd_we     = wr_ptr[0] ? st_we0     : st_we1;
    assign even_wdata = wr_ptr[0] ? st_inst[1] : st_inst[0];
    assign odd_wdata  = wr_ptr[0] ? st_inst[0] : st_inst[1];

    inst_queue_bank #(.ENTRIES(DEPTH / 2)) u_even (
        .clk   (clk),
        .we    (even_we),
        .waddr (even_waddr),
        .wdata (even_wdata),
        .raddr (even_raddr),
        .rdata (even_rdata)
    );

    inst_queue_bank #(.ENTRIES(DEPTH / 2)) u_odd (
        .clk   (clk),
        .we    (odd_we),
        .waddr (odd_waddr),
        .wdata (odd_wdata),
        .raddr (odd_raddr),
        .rdata (odd_rdata)
    );

    // ---------------- pointers / count ----------------
    // Reset and flush have the same effect; either one discards the cycle's
    // writes and issues.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(rd_adv);
            wr_ptr <= wr_ptr + PW'(st_n);
            count  <= count + CW'(st_n) - CW'(rd_adv);
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (q.w_valid_i != 2'b10)
                else $error("inst_queue: illegal w_valid_i pattern 2'b10");
            assert (q.issued_i != 2'b10)
                else $error("inst_queue: illegal issued_i pattern 2'b10");
        end
    end
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue (DEPTH=8, default build without bypass).
// Latency: n/a.
// Backpressure: bench holds a write pair until it sees w_ready_o high.
module tb_inst_queue;
    import inst_queue_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush_i;

    inst_queue_if qif();

    inst_queue #(.DEPTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_i),
        .q       (qif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic inst_t mk(input int n);
        inst_t t;
        t.pc = 16'(n * 4);
        t.op = 16'(16'hA000 + n);
        return t;
    endfunction

    // Apply one cycle of inputs, step past the edge, then idle the inputs.
    task automatic drive(input logic [1:0] wv, input int a, input int b,
                         input logic [1:0] iss, input logic fl);
        qif.w_valid_i   = wv;
        qif.w_inst_i[0] = mk(a);
        qif.w_inst_i[1] = mk(b);
        qif.issued_i    = iss;
        flush_i         = fl;
        @(posedge clk);
        #1;
        qif.w_valid_i = 2'b00;
        qif.issued_i  = 2'b00;
        flush_i       = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(2'b11, 90, 91, 2'b00, 1'b0);
        drive(2'b11, 92, 93, 2'b00, 1'b0);
        rst = 1'b0;
        n_checks++; if (qif.valid_o !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b want 00", qif.valid_o); end
        n_checks++; if (qif.w_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", qif.w_ready_o); end

        drive(2'b11, 1, 2, 2'b00, 1'b0);
        n_checks++; if (qif.valid_o !== 2'b11) begin n_fail++; $display("FAIL pair_valid: got %b want 11", qif.valid_o); end
        n_checks++; if (qif.inst_o[0] !== mk(1)) begin n_fail++; $display("FAIL pair_lane0: got %h want %h", qif.inst_o[0], mk(1)); end
        n_checks++; if (qif.inst_o[1] !== mk(2)) begin n_fail++; $display("FAIL pair_lane1: got %h want %h", qif.inst_o[1], mk(2)); end

        // Reset in the middle of traffic: nothing stale may survive.
        drive(2'b11, 3, 4, 2'b00, 1'b0);
        rst = 1'b1;
        drive(2'b11, 5, 6, 2'b11, 1'b0);
        rst = 1'b0;
        n_checks++; if (qif.valid_o !== 2'b00) begin n_fail++; $display("FAIL midrst_valid: got %b want 00", qif.valid_o); end
        n_checks++; if (qif.w_ready_o !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", qif.w_ready_o); end
        drive(2'b01, 7, 0, 2'b00, 1'b0);
        n_checks++; if (qif.valid_o !== 2'b01) begin n_fail++; $display("FAIL single_valid: got %b want 01", qif.valid_o); end
        n_checks++; if (qif.inst_o[0] !== mk(7)) begin n_fail++; $display("FAIL single_lane0: got %h want %h", qif.inst_o[0], mk(7)); end
        drive(2'b00, 0, 0, 2'b00, 1'b1);
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) drive(2'b11, 10 + 2*k, 11 + 2*k, 2'b00, 1'b0);
        n_checks++; if (qif.w_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", qif.w_ready_o); end
        n_checks++; if (qif.valid_o !== 2'b11) begin n_fail++; $display("FAIL full_valid: got %b want 11", qif.valid_o); end
        n_checks++; if (qif.inst_o[0] !== mk(10)) begin n_fail++; $display("FAIL full_head: got %h want %h", qif.inst_o[0], mk(10)); end

        // Fifth pair presented while full: dropped, decode keeps holding it.
        drive(2'b11, 18, 19, 2'b00, 1'b0);
        drive(2'b11, 18, 19, 2'b11, 1'b0);
        n_checks++; if (qif.w_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_reopen: got %b want 1", qif.w_ready_o); end
        n_checks++; if (qif.inst_o[0] !== mk(12)) begin n_fail++; $display("FAIL full_after_issue: got %h want %h", qif.inst_o[0], mk(12)); end
        drive(2'b11, 18, 19, 2'b00, 1'b0);
        n_checks++; if (qif.w_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_again: got %b want 0", qif.w_ready_o); end

        for (int k = 0; k < 4; k++) begin
            n_checks++; if (qif.inst_o[0] !== mk(12 + 2*k)) begin n_fail++; $display("FAIL drain_lane0[%0d]: got %h want %h", k, qif.inst_o[0], mk(12 + 2*k)); end
            n_checks++; if (qif.inst_o[1] !== mk(13 + 2*k)) begin n_fail++; $display("FAIL drain_lane1[%0d]: got %h want %h", k, qif.inst_o[1], mk(13 + 2*k)); end
            drive(2'b00, 0, 0, 2'b11, 1'b0);
        end
        n_checks++; if (qif.valid_o !== 2'b00) begin n_fail++; $display("FAIL drain_empty: got %b want 00", qif.valid_o); end
        drive(2'b00, 0, 0, 2'b00, 1'b1);
    endtask

    task automatic test_count7();
        for (int k = 0; k < 3; k++) drive(2'b11, 20 + 2*k, 21 + 2*k, 2'b00, 1'b0);
        drive(2'b01, 26, 0, 2'b00, 1'b0);
        n_checks++; if (qif.w_ready_o !== 1'b0) begin n_fail++; $display("FAIL c7_ready: got %b want 0", qif.w_ready_o); end
        n_checks++; if (qif.valid_o !== 2'b11) begin n_fail++; $display("FAIL c7_valid: got %b want 11", qif.valid_o); end
        drive(2'b00, 0, 0, 2'b01, 1'b0);
        n_checks++; if (qif.w_ready_o !== 1'b1) begin n_fail++; $display("FAIL c6_ready: got %b want 1", qif.w_ready_o); end
        n_checks++; if (qif.inst_o[0] !== mk(21)) begin n_fail++; $display("FAIL c6_lane0: got %h want %h", qif.inst_o[0], mk(21)); end
        n_checks++; if (qif.inst_o[1] !== mk(22)) begin n_fail++; $display("FAIL c6_lane1: got %h want %h", qif.inst_o[1], mk(22)); end
        drive(2'b00, 0, 0, 2'b00, 1'b1);
    endtask

    // Two writes per cycle against 2/1 alternating issue; occupancy climbs by
    // one every two cycles and the pointers wrap past index 7.
    task automatic test_wrap();
        int h, w, c, ni;
        logic acc;
        logic [1:0] iss;
        drive(2'b11, 30, 31, 2'b00, 1'b0);
        h = 30; w = 32; c = 2;
        for (int i = 0; i < 14; i++) begin
            iss = (i % 2 == 0) ? 2'b11 : 2'b01;
            ni  = (i % 2 == 0) ? 2 : 1;
            acc = (c <= 6);
            n_checks++; if (qif.w_ready_o !== acc) begin n_fail++; $display("FAIL wrap_ready[%0d]: got %b want %b", i, qif.w_ready_o, acc); end
            n_checks++; if (qif.inst_o[0] !== mk(h)) begin n_fail++; $display("FAIL wrap_lane0[%0d]: got %h want %h", i, qif.inst_o[0], mk(h)); end
            n_checks++; if (qif.inst_o[1] !== mk(h + 1)) begin n_fail++; $display("FAIL wrap_lane1[%0d]: got %h want %h", i, qif.inst_o[1], mk(h + 1)); end
            drive(2'b11, w, w + 1, iss, 1'b0);
            if (acc) w += 2;
            h += ni;
            c = c + (acc ? 2 : 0) - ni;
        end
        n_checks++; if (qif.w_ready_o !== (c <= 6)) begin n_fail++; $display("FAIL wrap_end_ready: got %b want %b", qif.w_ready_o, (c <= 6)); end
        n_checks++; if (qif.inst_o[0] !== mk(h)) begin n_fail++; $display("FAIL wrap_end_head: got %h want %h", qif.inst_o[0], mk(h)); end
        drive(2'b00, 0, 0, 2'b00, 1'b1);
    endtask

    task automatic test_flush();
        drive(2'b11, 40, 41, 2'b00, 1'b0);
        drive(2'b11, 42, 43, 2'b00, 1'b0);
        drive(2'b01, 44, 0, 2'b00, 1'b0);
        n_checks++; if (qif.inst_o[0] !== mk(40)) begin n_fail++; $display("FAIL fl_pre_head: got %h want %h", qif.inst_o[0], mk(40)); end
        drive(2'b11, 45, 46, 2'b11, 1'b1);
        n_checks++; if (qif.valid_o !== 2'b00) begin n_fail++; $display("FAIL fl_valid: got %b want 00", qif.valid_o); end
        n_checks++; if (qif.w_ready_o !== 1'b1) begin n_fail++; $display("FAIL fl_ready: got %b want 1", qif.w_ready_o); end
        drive(2'b11, 47, 48, 2'b00, 1'b0);
        n_checks++; if (qif.valid_o !== 2'b11) begin n_fail++; $display("FAIL fl_post_valid: got %b want 11", qif.valid_o); end
        n_checks++; if (qif.inst_o[0] !== mk(47)) begin n_fail++; $display("FAIL fl_post_lane0: got %h want %h", qif.inst_o[0], mk(47)); end
        n_checks++; if (qif.inst_o[1] !== mk(48)) begin n_fail++; $display("FAIL fl_post_lane1: got %h want %h", qif.inst_o[1], mk(48)); end
        drive(2'b00, 0, 0, 2'b00, 1'b1);
    endtask

    task automatic test_write_and_issue();
        drive(2'b01, 50, 0, 2'b00, 1'b0);
        n_checks++; if (qif.valid_o !== 2'b01) begin n_fail++; $display("FAIL wi_c1_valid: got %b want 01", qif.valid_o); end
        n_checks++; if (qif.inst_o[0] !== mk(50)) begin n_fail++; $display("FAIL wi_c1_lane0: got %h want %h", qif.inst_o[0], mk(50)); end
        drive(2'b11, 51, 52, 2'b01, 1'b0);
        n_checks++; if (qif.valid_o !== 2'b11) begin n_fail++; $display("FAIL wi_valid: got %b want 11", qif.valid_o); end
        n_checks++; if (qif.inst_o[0] !== mk(51)) begin n_fail++; $display("FAIL wi_lane0: got %h want %h", qif.inst_o[0], mk(51)); end
        n_checks++; if (qif.inst_o[1] !== mk(52)) begin n_fail++; $display("FAIL wi_lane1: got %h want %h", qif.inst_o[1], mk(52)); end
        n_checks++; if (qif.w_ready_o !== 1'b1) begin n_fail++; $display("FAIL wi_ready: got %b want 1", qif.w_ready_o); end
        drive(2'b00, 0, 0, 2'b11, 1'b0);
        n_checks++; if (qif.valid_o !== 2'b00) begin n_fail++; $display("FAIL wi_drained: got %b want 00", qif.valid_o); end
    endtask

    initial begin
        rst             = 1'b1;
        flush_i         = 1'b0;
        qif.w_valid_i   = 2'b00;
        qif.issued_i    = 2'b00;
        qif.w_inst_i[0] = '0;
        qif.w_inst_i[1] = '0;

        test_reset();
        test_full();
        test_count7();
        test_wrap();
        test_flush();
        test_write_and_issue();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
